uart_viterbi_frame_decoder: RTL and testbench
=============================================

# uart_viterbi_frame_decoder

Receive-side counterpart of the k=3 convolutional encoder path. The block collects one 8-byte encoded frame from the UART receiver byte stream and runs a 4-state hard-decision Viterbi decode with full-frame traceback. It then presents the recovered 32-bit word. It sits between `async_receiver` and the transmit/output logic in the top level.

## Interface
- No parameters. Frame geometry is fixed: 8 bytes in, 32 symbol pairs, 32 bits out.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_data_ready` in 1: one-cycle strobe from `async_receiver`; the byte on `rx_data` is valid.
- `rx_data` in 8: received byte.
- `frame_clear` in 1: synchronous abort, driven from a debounced button. Level-sensitive.
- `decoded_data` out 32: decoded word. Held until the next frame completes or until reset.
- `decoded_valid` out 1: one-cycle pulse when `decoded_data` updates.
- `busy` out 1: high in ACS, TRACE and DONE.
- `byte_count` out 3: number of bytes collected so far in the current frame.
- `overrun` out 1: sticky. Set when a byte arrives while `busy` is high.
- `path_metric` out 7: winning path metric, i.e. the count of corrected channel bits (see Configuration).

## Operation
- **Encoder convention the decoder inverts.** Input bits b[0..31] are taken LSB first. State s = {b[t-1], b[t-2]} and starts at 00.
  - out0 = b ^ b[t-1] ^ b[t-2]; out1 = b ^ b[t-2].
  - Frame bit 2t carries out0; frame bit 2t+1 carries out1.
  - Byte k of the frame occupies bits 8k+7:8k. Bytes arrive k = 0 first.
- **COLLECT** (reset state):
  - Each `rx_data_ready` stores `rx_data` into frame byte `byte_count`, then increments `byte_count`.
  - On the 8th byte: enter ACS. `byte_count` returns to 0.
- **ACS**, 32 cycles, step t = 0..31, one step per cycle:
  - Branch metric = Hamming distance (0..2) between the received pair and the expected pair.
  - New state s = {b, b1} has predecessors {b1, 0} and {b1, 1}.
  - Select the smaller sum. On a tie, take predecessor 0.
  - Store decision bit d[t][s] = the chosen predecessor's LSB. Survivor memory is 32x4 flops.
  - Initial metrics: state 00 = 0, all other states = 7'd64, which acts as infinity.
  - Maximum real metric is 64, so metrics are 7 bits with no wrap and no normalisation.
- **TRACE**, 32 cycles, t = 31 down to 0:
  - Start state = the state with the minimum final metric. On a tie, take the lowest index.
  - Each cycle: `decoded_data[t]` ← s[1] into a shadow register; next s = {s[0], d[t][s]}.
- **DONE**, 1 cycle: copy the shadow register to `decoded_data`, pulse `decoded_valid`, return to COLLECT.
- **`frame_clear`**, from any state:
  - Next state COLLECT, `byte_count` = 0, `overrun` = 0.
  - Partial decode is discarded; `decoded_data` is unchanged.
  - If `rx_data_ready` is high in the same cycle, `frame_clear` wins and the byte is dropped.
- **Overrun:** bytes arriving while `busy` is high are dropped and set `overrun`.

## Timing
- Reset values: `decoded_data` = 0, `decoded_valid` = 0, `busy` = 0, `byte_count` = 0, `overrun` = 0, `path_metric` = 0. State = COLLECT.
- Let edge E0 be the edge that accepts byte 7. Then:
  - ACS runs on edges E1–E32.
  - TRACE runs on edges E33–E64.
  - Edge E65 registers `decoded_valid` = 1 along with the new `decoded_data` and `path_metric`.
  - `busy` is high from after E0 until after E65.
- A byte strobe on the cycle after `decoded_valid` is accepted as byte 0 of the next frame.
- `rst_n` asserted mid-ACS or mid-TRACE: everything returns to reset values immediately, with no output pulse.
- Throughput: one frame per 66 cycles plus UART byte time. UART byte time dominates.

## Configuration
- `VITERBI_METRIC_EN`
  - Defined: `path_metric` latches the winning metric at E65 and holds it with `decoded_data`.
  - Undefined: the metric register is not built and `path_metric` is tied to 0. Decoding is unchanged.

## Test plan
- Error-free all-ones frame: bytes 5B, 55, 55, 55, 55, 55, 55, 55 → `decoded_data` = FFFFFFFF, `path_metric` = 0, pulse at E65.
- Single channel error: same frame with byte 3 = 54 → `decoded_data` = FFFFFFFF, `path_metric` = 1 when `VITERBI_METRIC_EN` is defined, 0 otherwise.
- All-zero frame with byte 0 = 01 → `decoded_data` = 00000000, `path_metric` = 1. Follow with 8 × 00 → 00000000, metric 0.
- Overrun: send a 9th byte at E10 → byte ignored, `overrun` = 1, result still correct. `frame_clear` then returns `overrun` to 0.
- Abort: `frame_clear` after 5 bytes, then a full error-free frame → decode uses only the new 8 bytes, with no stale pulse.
- Reset mid-TRACE at E40 → all outputs return to 0 and no `decoded_valid` is produced. The next full frame decodes normally.

Source files
------------

// File: rtl/uart_viterbi_frame_decoder.sv
// Collects an 8-byte k=3 convolutionally encoded frame and recovers 32 bits by hard-decision Viterbi.
// Optional: define VITERBI_METRIC_EN to register the winning path metric on path_metric.
module uart_viterbi_frame_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_data_ready,
    input  logic [7:0]  rx_data,
    input  logic        frame_clear,
    output logic [31:0] decoded_data,
    output logic        decoded_valid,
    output logic        busy,
    output logic [2:0]  byte_count,
    output logic        overrun,
    output logic [6:0]  path_metric
);

    typedef enum logic [1:0] {S_COLLECT, S_ACS, S_TRACE, S_DONE} state_t;

    state_t          state, state_nx;
    logic [4:0]      step;
    logic [63:0]     frame;
    logic [3:0][6:0] pm, pm_nx, sum0, sum1;
    logic [3:0]      dec;
    logic [3:0]      surv [32];
    logic [1:0]      tb_s, cur_s, best_s;
    logic [6:0]      best_m;
    logic [31:0]     shadow;
    logic            r0, r1;

    // Path metric through predecessor {b1,c} into state {b,b1}
    function automatic logic [6:0] branch(input logic [6:0] m, input logic b, input logic b1,
                                          input logic c, input logic rx0, input logic rx1);
        logic e0, e1;
        e0 = b ^ b1 ^ c;
        e1 = b ^ c;
        return m + 7'(e0 ^ rx0) + 7'(e1 ^ rx1);
    endfunction

    assign r0   = frame[{step, 1'b0}];
    assign r1   = frame[{step, 1'b1}];
    assign busy = (state != S_COLLECT);

    always_comb begin
        sum0  = '0;
        sum1  = '0;
        dec   = '0;
        pm_nx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sum0[i]  = branch(pm[{i[0], 1'b0}], i[1], i[0], 1'b0, r0, r1);
            sum1[i]  = branch(pm[{i[0], 1'b1}], i[1], i[0], 1'b1, r0, r1);
            dec[i]   = (sum1[i] < sum0[i]);
            pm_nx[i] = dec[i] ? sum1[i] : sum0[i];
        end
    end

    always_comb begin
        best_s = 2'd0;
        best_m = pm[0];
        for (int unsigned i = 1; i < 4; i++) begin
            if (pm[i] < best_m) begin
                best_m = pm[i];
                best_s = 2'(i);
            end
        end
    end

    // Traceback starts from the best final state on its first cycle (step 31)
    assign cur_s = (step == 5'd31) ? best_s : tb_s;

    always_comb begin
        state_nx = state;
        case (state)
            S_COLLECT: if (rx_data_ready && byte_count == 3'd7) state_nx = S_ACS;
            S_ACS:     if (step == 5'd31) state_nx = S_TRACE;
            S_TRACE:   if (step == 5'd0) state_nx = S_DONE;
            S_DONE:    state_nx = S_COLLECT;
            default:   state_nx = S_COLLECT;
        endcase
        if (frame_clear) state_nx = S_COLLECT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_COLLECT;
            step          <= '0;
            frame         <= '0;
            pm            <= {7'd64, 7'd64, 7'd64, 7'd0};
            tb_s          <= '0;
            shadow        <= '0;
            decoded_data  <= '0;
            decoded_valid <= 1'b0;
            byte_count    <= '0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_nx;
            decoded_valid <= 1'b0;
            if (frame_clear) begin
                byte_count <= '0;
                overrun    <= 1'b0;
            end else begin
                if (busy && rx_data_ready) overrun <= 1'b1;
                case (state)
                    S_COLLECT: if (rx_data_ready) begin
                        frame[{byte_count, 3'b000} +: 8] <= rx_data;
                        byte_count <= byte_count + 3'd1;
                        pm         <= {7'd64, 7'd64, 7'd64, 7'd0};
                        step       <= '0;
                    end
                    S_ACS: begin
                        pm   <= pm_nx;
                        step <= (step == 5'd31) ? step : step + 5'd1;
                    end
                    S_TRACE: begin
                        shadow[step] <= cur_s[1];
                        tb_s         <= {cur_s[0], surv[step][cur_s]};
                        step         <= step - 5'd1;
                    end
                    S_DONE: begin
                        decoded_data  <= shadow;
                        decoded_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_ACS) surv[step] <= dec;
    end

`ifdef VITERBI_METRIC_EN
    logic [6:0] metric_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) metric_q <= '0;
        else if (state == S_DONE && !frame_clear) metric_q <= best_m;
    end

    assign path_metric = metric_q;
`else
    assign path_metric = '0;
`endif

endmodule

// File: tb/tb_uart_viterbi_frame_decoder.sv
// Directed bench for uart_viterbi_frame_decoder: known frames, latency, overrun, abort and reset.
// Metric expectations follow VITERBI_METRIC_EN.
module tb_uart_viterbi_frame_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_data_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        frame_clear = 1'b0;
    logic [31:0] decoded_data;
    logic        decoded_valid;
    logic        busy;
    logic [2:0]  byte_count;
    logic        overrun;
    logic [6:0]  path_metric;

    int tests = 0;
    int fails = 0;

    uart_viterbi_frame_decoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data_ready (rx_data_ready),
        .rx_data       (rx_data),
        .frame_clear   (frame_clear),
        .decoded_data  (decoded_data),
        .decoded_valid (decoded_valid),
        .busy          (busy),
        .byte_count    (byte_count),
        .overrun       (overrun),
        .path_metric   (path_metric)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data       = b;
        rx_data_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_data_ready = 1'b0;
    endtask

    // act: 0 none, 1 extra byte at edge act_edge, 2 reset asserted just before edge act_edge
    task automatic run_frame(input string tag, input logic [63:0] f, input logic [31:0] exp_d,
                             input logic [6:0] exp_m, input int act_edge, input int act);
        int         lat;
        logic [6:0] m;
`ifdef VITERBI_METRIC_EN
        m = exp_m;
`else
        m = 7'd0;
`endif
        lat = 0;
        send_byte(f[7:0]);
        check({tag, " count1"}, 32'(byte_count), 32'd1);
        for (int k = 1; k < 8; k++) send_byte(f[k*8 +: 8]);
        check({tag, " busy@E0"}, 32'(busy), 32'd1);
        check({tag, " count@E0"}, 32'(byte_count), 32'd0);
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            if (n == act_edge && act == 1) begin
                rx_data       = 8'hA5;
                rx_data_ready = 1'b1;
            end
            if (n == act_edge && act == 2) rst_n = 1'b0;
            @(posedge clk);
            #1;
            rx_data_ready = 1'b0;
            if (decoded_valid) begin
                lat = n;
                break;
            end
        end
        if (act == 2) begin
            check({tag, " no pulse"}, 32'(lat), 32'd0);
            check({tag, " rst data"}, decoded_data, 32'd0);
            check({tag, " rst busy"}, 32'(busy), 32'd0);
            check({tag, " rst metric"}, 32'(path_metric), 32'd0);
            check({tag, " rst count"}, 32'(byte_count), 32'd0);
        end else begin
            check({tag, " latency"}, 32'(lat), 32'd65);
            check({tag, " data"}, decoded_data, exp_d);
            check({tag, " metric"}, 32'(path_metric), 32'(m));
            check({tag, " busy after"}, 32'(busy), 32'd0);
            if (act == 1) check({tag, " overrun"}, 32'(overrun), 32'd1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst data", decoded_data, 32'd0);
        check("rst valid", 32'(decoded_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst count", 32'(byte_count), 32'd0);
        check("rst overrun", 32'(overrun), 32'd0);
        check("rst metric", 32'(path_metric), 32'd0);

        run_frame("ones", 64'h55555555_5555555B, 32'hFFFFFFFF, 7'd0, 0, 0);
        @(posedge clk);
        #1;
        check("ones pulse end", 32'(decoded_valid), 32'd0);

        // Back-to-back frames also exercise a byte on the cycle right after decoded_valid
        run_frame("ones err", 64'h55555555_5455555B, 32'hFFFFFFFF, 7'd1, 0, 0);
        run_frame("zero err", 64'h00000000_00000001, 32'h00000000, 7'd1, 0, 0);
        run_frame("zeros", 64'h0, 32'h00000000, 7'd0, 0, 0);

        run_frame("ovr", 64'h55555555_5555555B, 32'hFFFFFFFF, 7'd0, 10, 1);
        @(negedge clk);
        frame_clear = 1'b1;
        @(posedge clk);
        #1;
        frame_clear = 1'b0;
        check("ovr cleared", 32'(overrun), 32'd0);

        for (int k = 0; k < 5; k++) send_byte(8'hFF);
        check("abort count5", 32'(byte_count), 32'd5);
        @(negedge clk);
        frame_clear   = 1'b1;
        rx_data       = 8'hFF;
        rx_data_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_clear   = 1'b0;
        rx_data_ready = 1'b0;
        check("abort count0", 32'(byte_count), 32'd0);
        check("abort no pulse", 32'(decoded_valid), 32'd0);
        run_frame("abort new", 64'h0, 32'h00000000, 7'd0, 0, 0);
        check("abort overrun", 32'(overrun), 32'd0);

        run_frame("reset mid", 64'h55555555_5555555B, 32'h0, 7'd0, 40, 2);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("post reset", 64'h55555555_5555555B, 32'hFFFFFFFF, 7'd0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
